// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : Machine-mode CSR storage for the RV32IM core: combinational read,
//            write-back from the CSR unit, 64-bit counters, trap/mret updates.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] HART_ID  = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL = 32'h4000_1100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        csr_w_en_i,
    output logic        illegal_o,
    input  logic        retire_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_val_i,
    input  logic        mret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_ADDR_MISA      = 12'h301;
    localparam logic [11:0] c_ADDR_MIE       = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] c_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] c_ADDR_MIP       = 12'h344;
    localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] c_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] c_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] c_ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] c_ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] c_MIE_MASK   = 32'h0000_0888;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [1:0]  c_MPP_M      = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,          mie_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [31:0] mtval_q,        mtval_d;
    logic [63:0] mcycle_q,       mcycle_d;
    logic [63:0] minstret_q,     minstret_d;

    logic [31:0] w_mstatus;
    logic [31:0] w_rdata;
    logic        w_rd_valid;
    logic        w_wr_legal;
    logic        w_wr_en;

    assign w_mstatus = {19'b0, c_MPP_M, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata    = 32'h0;
        w_rd_valid = 1'b1;
        case (csr_raddr_i)
            c_ADDR_MSTATUS:   w_rdata = w_mstatus;
            c_ADDR_MISA:      w_rdata = MISA_VAL;
            c_ADDR_MIE:       w_rdata = mie_q;
            c_ADDR_MTVEC:     w_rdata = mtvec_q;
            c_ADDR_MSCRATCH:  w_rdata = mscratch_q;
            c_ADDR_MEPC:      w_rdata = mepc_q;
            c_ADDR_MCAUSE:    w_rdata = mcause_q;
            c_ADDR_MTVAL:     w_rdata = mtval_q;
            c_ADDR_MIP:       w_rdata = 32'h0;
            c_ADDR_MCYCLE,
            c_ADDR_CYCLE:     w_rdata = mcycle_q[31:0];
            c_ADDR_MCYCLEH,
            c_ADDR_CYCLEH:    w_rdata = mcycle_q[63:32];
            c_ADDR_MINSTRET,
            c_ADDR_INSTRET:   w_rdata = minstret_q[31:0];
            c_ADDR_MINSTRETH,
            c_ADDR_INSTRETH:  w_rdata = minstret_q[63:32];
            c_ADDR_MHARTID:   w_rdata = HART_ID;
            default: begin
                w_rdata    = 32'h0;
                w_rd_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write legality
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_legal = 1'b0;
        case (csr_waddr_i)
            c_ADDR_MSTATUS,
            c_ADDR_MIE,
            c_ADDR_MTVEC,
            c_ADDR_MSCRATCH,
            c_ADDR_MEPC,
            c_ADDR_MCAUSE,
            c_ADDR_MTVAL,
            c_ADDR_MCYCLE,
            c_ADDR_MCYCLEH,
            c_ADDR_MINSTRET,
            c_ADDR_MINSTRETH: w_wr_legal = 1'b1;
            default:          w_wr_legal = 1'b0;
        endcase
    end

    // Trap and mret both pre-empt a software write in the same cycle.
    assign w_wr_en = csr_w_en_i & w_wr_legal & ~trap_i & ~mret_i;

    // ------------------------------------------------------------------------
    // Counters: a software write to one half freezes the whole counter that cycle
    // ------------------------------------------------------------------------
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (w_wr_en && (csr_waddr_i == c_ADDR_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], csr_wdata_i};
        end else if (w_wr_en && (csr_waddr_i == c_ADDR_MCYCLEH)) begin
            mcycle_d = {csr_wdata_i, mcycle_q[31:0]};
        end
    end

    always_comb begin
        minstret_d = retire_i ? (minstret_q + 64'd1) : minstret_q;
        if (w_wr_en && (csr_waddr_i == c_ADDR_MINSTRET)) begin
            minstret_d = {minstret_q[63:32], csr_wdata_i};
        end else if (w_wr_en && (csr_waddr_i == c_ADDR_MINSTRETH)) begin
            minstret_d = {csr_wdata_i, minstret_q[31:0]};
        end
    end

    // ------------------------------------------------------------------------
    // Architectural register update: trap > mret > software write
    // ------------------------------------------------------------------------
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (trap_i) begin
            mepc_d         = trap_pc_i & c_ALIGN_MASK;
            mcause_d       = trap_cause_i;
            mtval_d        = trap_val_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (w_wr_en) begin
            case (csr_waddr_i)
                c_ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata_i[3];
                    mstatus_mpie_d = csr_wdata_i[7];
                end
                c_ADDR_MIE:      mie_d      = csr_wdata_i & c_MIE_MASK;
                c_ADDR_MTVEC:    mtvec_d    = csr_wdata_i & c_ALIGN_MASK;
                c_ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
                c_ADDR_MEPC:     mepc_d     = csr_wdata_i & c_ALIGN_MASK;
                c_ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
                c_ADDR_MTVAL:    mtval_d    = csr_wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= 32'h0;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign csr_rdata_o = w_rdata;
    assign illegal_o   = ~w_rd_valid | (csr_w_en_i & ~w_wr_legal);
    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;
    assign mie_o       = mstatus_mie_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Self-checking bench for csr_file: vector table plus directed
//            trap, mret, counter and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] c_HART_ID = 32'h0000_0005;

    logic        clk;
    logic        reset;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_w_en_i;
    logic        illegal_o;
    logic        retire_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_val_i;
    logic        mret_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    int checks   = 0;
    int failures = 0;

    csr_file #(
        .HART_ID  (c_HART_ID),
        .MISA_VAL (32'h4000_1100)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .csr_raddr_i  (csr_raddr_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_w_en_i   (csr_w_en_i),
        .illegal_o    (illegal_o),
        .retire_i     (retire_i),
        .trap_i       (trap_i),
        .trap_cause_i (trap_cause_i),
        .trap_pc_i    (trap_pc_i),
        .trap_val_i   (trap_val_i),
        .mret_i       (mret_i),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mie_o        (mie_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [0:17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_w_en_i  = 1'b1;
        csr_waddr_i = addr;
        csr_wdata_i = data;
        tick();
        csr_w_en_i  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        csr_raddr_i = addr;
        #1;
        check(name, csr_rdata_o, exp);
    endtask

    initial begin
        reset        = 1'b1;
        csr_raddr_i  = 12'h0;
        csr_waddr_i  = 12'h0;
        csr_wdata_i  = 32'h0;
        csr_w_en_i   = 1'b0;
        retire_i     = 1'b0;
        trap_i       = 1'b0;
        trap_cause_i = 32'h0;
        trap_pc_i    = 32'h0;
        trap_val_i   = 32'h0;
        mret_i       = 1'b0;

        //           we    waddr    wdata          raddr    exp_rdata      ill
        vecs[0]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h300, 32'h0000_1800, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h301, 32'h4000_1100, 1'b0};
        vecs[2]  = '{1'b0, 12'h000, 32'h0000_0000, 12'hF14, c_HART_ID,     1'b0};
        vecs[3]  = '{1'b1, 12'h305, 32'h8000_0103, 12'h305, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h305, 32'h8000_0100, 1'b0};
        vecs[5]  = '{1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h340, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h304, 32'h0000_0888, 1'b0};
        vecs[9]  = '{1'b1, 12'hC00, 32'h0000_0001, 12'h344, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 12'h123, 32'h0000_0005, 12'h340, 32'hDEAD_BEEF, 1'b1};
        vecs[11] = '{1'b0, 12'h000, 32'h0000_0000, 12'h123, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 12'h341, 32'h1234_5677, 12'h341, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 12'h000, 32'h0000_0000, 12'h341, 32'h1234_5674, 1'b0};
        vecs[14] = '{1'b1, 12'h301, 32'h0000_0000, 12'h301, 32'h4000_1100, 1'b1};
        vecs[15] = '{1'b0, 12'h000, 32'h0000_0000, 12'h301, 32'h4000_1100, 1'b0};
        vecs[16] = '{1'b1, 12'h343, 32'hA5A5_A5A5, 12'h343, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 12'h000, 32'h0000_0000, 12'h343, 32'hA5A5_A5A5, 1'b0};

        tick();
        tick();
        reset = 1'b0;

        check("reset_mtvec_o", mtvec_o, 32'h0);
        check("reset_mepc_o",  mepc_o,  32'h0);
        check("reset_mie_o",   {31'b0, mie_o}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            csr_w_en_i  = vecs[i].we;
            csr_waddr_i = vecs[i].waddr;
            csr_wdata_i = vecs[i].wdata;
            csr_raddr_i = vecs[i].raddr;
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), csr_rdata_o, vecs[i].exp_rdata);
            check($sformatf("vec%0d_illegal", i), {31'b0, illegal_o}, {31'b0, vecs[i].exp_ill});
            tick();
        end
        csr_w_en_i = 1'b0;
        check("mtvec_o_after_write", mtvec_o, 32'h8000_0100);

        // Trap entry followed by mret
        wr(12'h300, 32'h0000_0008);
        rd(12'h300, 32'h0000_1808, "mstatus_mie_set");
        check("mie_o_set", {31'b0, mie_o}, 32'h1);
        trap_i       = 1'b1;
        trap_cause_i = 32'h0000_000B;
        trap_pc_i    = 32'h0000_0100;
        trap_val_i   = 32'h0000_0077;
        tick();
        trap_i = 1'b0;
        rd(12'h342, 32'h0000_000B, "trap_mcause");
        rd(12'h343, 32'h0000_0077, "trap_mtval");
        rd(12'h300, 32'h0000_1880, "trap_mstatus");
        check("trap_mepc_o", mepc_o, 32'h0000_0100);
        check("trap_mie_o", {31'b0, mie_o}, 32'h0);
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        rd(12'h300, 32'h0000_1888, "mret_mstatus");
        check("mret_mie_o", {31'b0, mie_o}, 32'h1);

        // mcycle carry from low into high half
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0000_0000);
        rd(12'hB80, 32'h0000_0000, "mcycleh_loaded");
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_held");
        tick();
        rd(12'hB00, 32'h0000_0000, "mcycle_wrapped");
        rd(12'hB80, 32'h0000_0001, "mcycleh_carry");
        tick();
        rd(12'hC80, 32'h0000_0001, "cycleh_shadow");
        rd(12'hC00, 32'h0000_0001, "cycle_shadow");

        // Five retire pulses spread over twelve cycles
        wr(12'hB82, 32'h0000_0000);
        wr(12'hB02, 32'h0000_0000);
        begin
            logic [11:0] pattern;
            pattern = 12'b1001_0001_1010;
            for (int c = 0; c < 12; c++) begin
                retire_i = pattern[c];
                tick();
            end
            retire_i = 1'b0;
        end
        rd(12'hB02, 32'h0000_0005, "minstret_count");
        rd(12'hC02, 32'h0000_0005, "instret_shadow");
        rd(12'hB82, 32'h0000_0000, "minstreth_zero");
        tick();

        // trap, mret and mepc write together: trap wins
        wr(12'h300, 32'h0000_0008);
        trap_i       = 1'b1;
        mret_i       = 1'b1;
        csr_w_en_i   = 1'b1;
        csr_waddr_i  = 12'h341;
        csr_wdata_i  = 32'h0000_0044;
        trap_cause_i = 32'h0000_0007;
        trap_pc_i    = 32'h0000_0203;
        trap_val_i   = 32'h0000_0000;
        tick();
        trap_i     = 1'b0;
        mret_i     = 1'b0;
        csr_w_en_i = 1'b0;
        check("prio_mepc_o", mepc_o, 32'h0000_0200);
        check("prio_mie_o", {31'b0, mie_o}, 32'h0);
        rd(12'h342, 32'h0000_0007, "prio_mcause");
        rd(12'h300, 32'h0000_1880, "prio_mstatus");

        // Reset mid-operation overrides a concurrent write
        reset       = 1'b1;
        csr_w_en_i  = 1'b1;
        csr_waddr_i = 12'h340;
        csr_wdata_i = 32'h0000_1234;
        tick();
        reset      = 1'b0;
        csr_w_en_i = 1'b0;
        rd(12'hB00, 32'h0000_0000, "rst_mcycle");
        rd(12'h340, 32'h0000_0000, "rst_mscratch");
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        check("rst_mtvec_o", mtvec_o, 32'h0);
        check("rst_mepc_o",  mepc_o,  32'h0);
        check("rst_mie_o",   {31'b0, mie_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32IM core, holding all architectural CSR state.
- Serves as the storage end of the CSR read-modify-write path.
  - Provides the current CSR value, combinationally, to the CSR execute unit.
  - Accepts the computed new value and write enable back from that unit.
- Also owns the 64-bit cycle and instret counters.
- Performs trap entry and mret state updates for the pipeline.

Parameters:
- HART_ID, 32'h0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h40001100, read-only misa value (MXL=1, I, M).

Ports:
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- csr_raddr_i  in  12  read address (core_package::csr_e encoding)
- csr_rdata_o  out  32  combinational read data for csr_raddr_i
- csr_waddr_i  in  12  write address
- csr_wdata_i  in  32  write data
- csr_w_en_i  in  1  write strobe, applied at next posedge
- illegal_o  out  1  combinational: read address unimplemented, or write to read-only/unimplemented address
- retire_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap entry request (one cycle)
- trap_cause_i  in  32  mcause value for the trap
- trap_pc_i  in  32  PC of the trapping instruction
- trap_val_i  in  32  mtval value
- mret_i  in  1  mret executed (one cycle)
- mtvec_o  out  32  current mtvec, {base[31:2],2'b00}
- mepc_o  out  32  current mepc
- mie_o  out  1  mstatus.MIE

Behaviour:
- Reset (sync, active-high, posedge): all registers and counters become 0; mstatus.MPP reads 2'b11 always.
- Reset values seen at the outputs:
  - mtvec_o=0, mepc_o=0, mie_o=0.
  - csr_rdata_o reflects the reset state.
- Implemented registers:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 11; all other bits read 0.
  - misa 0x301: read-only MISA_VAL.
  - mie 0x304: bits 3, 7, 11 writable; other bits read 0.
  - mtvec 0x305: direct mode only; bits[1:0] forced 0 on write.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342, mtval 0x343: full 32 bits.
  - mip 0x344: read-only 0.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: read/write.
  - cycle 0xC00/0xC80, instret 0xC02/0xC82: read-only shadows of the counters.
  - mhartid 0xF14: read-only HART_ID.
- Read path:
  - Purely combinational; zero latency.
  - Unimplemented address returns 0 and raises illegal_o.
  - Read-during-write to the same address returns the old value; the new value is visible the next cycle.
- Write path:
  - Write takes effect at the posedge where csr_w_en_i=1.
  - Write to a read-only or unimplemented address: no state change, illegal_o=1 that cycle.
- Counters:
  - mcycle increments by 1 every cycle out of reset; 64-bit, wraps 2^64-1 -> 0.
  - minstret increments when retire_i=1.
  - Software write to one half loads csr_wdata_i into that half; the other half holds; no increment that cycle for that counter.
- Trap entry (trap_i=1), in one cycle:
  - mepc <= {trap_pc_i[31:2],00}
  - mcause <= trap_cause_i
  - mtval <= trap_val_i
  - MPIE <= MIE, MIE <= 0
- mret (mret_i=1): MIE <= MPIE, MPIE <= 1.
- Priority within one cycle is trap_i > mret_i > csr_w_en_i:
  - The lower-priority request is dropped; the pipeline guarantees no retry is needed.
  - Counter increments still occur during trap and mret.
- Reset asserted mid-operation overrides all other inputs in that cycle.

Test Plan:
- Reset then read 0x300, 0x301, 0xF14 -> 0x00001800, 0x40001100, HART_ID; illegal_o=0.
- Write mtvec=0x8000_0103 -> next-cycle read 0x8000_0100, mtvec_o=0x8000_0100; same-cycle read returns 0.
- Set MIE via mstatus=0x8, then trap_i with cause=0x0000_000B, pc=0x100 -> mepc=0x100, mcause=0xB, MIE=0, MPIE=1.
  - Follow with mret_i -> MIE=1, MPIE=1.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 -> one cycle later mcycle=0, mcycleh=1.
  - minstret counts exactly 5 after 5 retire_i pulses spread over 12 cycles.
- Write 0xC00 or 0x123 with csr_w_en_i=1 -> illegal_o=1, no state change.
  - Read 0x123 -> data 0, illegal_o=1.
- trap_i, mret_i and write mepc=0x44 in the same cycle -> trap result only (mepc=trap_pc_i), MIE=0.
  - Assert reset during the next cycle -> all state returns to reset values.
